// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and constants for gray_counter
//
// Contents:
//   conv_dir_e  conversion direction selector for gray_conv (B2G / G2B)
//   CNT_ZERO    32-bit all-zeros constant (callers slice to their width)
//   CNT_ONES    32-bit all-ones constant (callers slice to their width)
//   bin2gray    binary -> Gray, up to 32 bits
//   gray2bin    Gray -> binary, up to 32 bits
package gray_pkg;

    typedef enum logic {
        B2G = 1'b0,
        G2B = 1'b1
    } conv_dir_e;

    localparam logic [31:0] CNT_ZERO = 32'h0000_0000;
    localparam logic [31:0] CNT_ONES = 32'hFFFF_FFFF;

    // Narrower values are zero-extended by the caller. The zero upper bits
    // leave the low bits of the result unchanged.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down. Zero-extended upper bits contribute nothing.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_conv.sv
// rtl/gray_conv.sv - combinational binary/Gray converter wrapping gray_pkg
//
// Parameters:
//   WIDTH  bus width, 2..32
//   DIR    B2G: dout = bin2gray(din); G2B: dout = gray2bin(din)
// Ports:
//   din   in   WIDTH  value to convert
//   dout  out  WIDTH  converted value
module gray_conv
    import gray_pkg::*;
#(
    parameter int        WIDTH = 4,
    parameter conv_dir_e DIR   = B2G
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [31:0] wide_in;

    assign wide_in = 32'(din);

    generate
        if (DIR == B2G) begin : g_b2g
            assign dout = WIDTH'(bin2gray(wide_in));
        end else begin : g_g2b
            assign dout = WIDTH'(gray2bin(wide_in));
        end
    endgenerate

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - registered Gray-code up/down counter with wrap/saturate
//
// Optional feature macro: GRAY_CNT_LOAD_EN (adds load / load_gray ports).
// Parameters:
//   WIDTH      counter width, 2..32
//   WRAP_MODE  1 = wrap at the ends, 0 = saturate at the ends
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      advance one step this cycle
//   up         in   1      1 = count up, 0 = count down (used only when en=1)
//   load       in   1      parallel load strobe, priority over en (macro only)
//   load_gray  in   WIDTH  Gray-coded load value (macro only)
//   cnt_bin    out  WIDTH  registered binary count
//   cnt_gray   out  WIDTH  registered Gray count
//   tc         out  1      registered one-cycle terminal-count pulse
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int WRAP_MODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
`ifdef GRAY_CNT_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
`endif
    output logic [WIDTH-1:0] cnt_bin,
    output logic [WIDTH-1:0] cnt_gray,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO = CNT_ZERO[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONES = CNT_ONES[WIDTH-1:0];

    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             tc_nxt;

`ifdef GRAY_CNT_LOAD_EN
    logic [WIDTH-1:0] load_bin;

    gray_conv #(
        .WIDTH (WIDTH),
        .DIR   (G2B)
    ) u_load_conv (
        .din  (load_gray),
        .dout (load_bin)
    );
`endif

    // End detection compares against constants, not the adder carry, so the
    // saturate case can hold without an extra adder bit.
    always_comb begin
        b_nxt  = cnt_bin;
        tc_nxt = 1'b0;
`ifdef GRAY_CNT_LOAD_EN
        if (load) begin
            b_nxt = load_bin;
        end else
`endif
        if (en) begin
            if (up) begin
                if (cnt_bin == ONES) begin
                    tc_nxt = 1'b1;
                    if (WRAP_MODE != 0) begin
                        b_nxt = ZERO;
                    end
                end else begin
                    b_nxt = cnt_bin + WIDTH'(1);
                end
            end else begin
                if (cnt_bin == ZERO) begin
                    tc_nxt = 1'b1;
                    if (WRAP_MODE != 0) begin
                        b_nxt = ONES;
                    end
                end else begin
                    b_nxt = cnt_bin - WIDTH'(1);
                end
            end
        end
    end

    // The Gray output is registered from the next-state value so that it
    // comes straight from flops and never glitches downstream of a CDC.
    gray_conv #(
        .WIDTH (WIDTH),
        .DIR   (B2G)
    ) u_next_conv (
        .din  (b_nxt),
        .dout (gray_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_bin  <= '0;
            cnt_gray <= '0;
            tc       <= 1'b0;
        end else begin
            cnt_bin  <= b_nxt;
            cnt_gray <= gray_nxt;
            tc       <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - directed self-checking bench for gray_counter
module tb_gray_counter;

    localparam int W = 4;

    typedef struct {
        logic         en;
        logic         up;
        logic [W-1:0] bin;
        logic [W-1:0] gray;
        logic         tc;
        string        name;
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         en    = 1'b0;
    logic         up    = 1'b0;
    logic         en_s  = 1'b0;
    logic         up_s  = 1'b0;
    logic [W-1:0] cnt_bin, cnt_gray, s_bin, s_gray;
    logic         tc, s_tc;
`ifdef GRAY_CNT_LOAD_EN
    logic         load      = 1'b0;
    logic [W-1:0] load_gray = '0;
    logic         load_s    = 1'b0;
    logic [W-1:0] load_gray_s = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(W), .WRAP_MODE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
`ifdef GRAY_CNT_LOAD_EN
        .load      (load),
        .load_gray (load_gray),
`endif
        .cnt_bin   (cnt_bin),
        .cnt_gray  (cnt_gray),
        .tc        (tc)
    );

    gray_counter #(.WIDTH(W), .WRAP_MODE(0)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_s),
        .up        (up_s),
`ifdef GRAY_CNT_LOAD_EN
        .load      (load_s),
        .load_gray (load_gray_s),
`endif
        .cnt_bin   (s_bin),
        .cnt_gray  (s_gray),
        .tc        (s_tc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_main(input string name, input logic [W-1:0] b,
                            input logic [W-1:0] g, input logic t);
        chk({name, ".bin"},  32'(cnt_bin),  32'(b));
        chk({name, ".gray"}, 32'(cnt_gray), 32'(g));
        chk({name, ".tc"},   32'(tc),       32'(t));
    endtask

    task automatic chk_sat(input string name, input logic [W-1:0] b,
                           input logic [W-1:0] g, input logic t);
        chk({name, ".bin"},  32'(s_bin),  32'(b));
        chk({name, ".gray"}, 32'(s_gray), 32'(g));
        chk({name, ".tc"},   32'(s_tc),   32'(t));
    endtask

    task automatic add(input logic e, input logic u, input logic [W-1:0] b,
                       input logic [W-1:0] g, input logic t, input string n);
        vec_t v;
        v.en = e; v.up = u; v.bin = b; v.gray = g; v.tc = t; v.name = n;
        vecs.push_back(v);
    endtask

    // Step one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; en_s = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] up_gray [16];
        logic [W-1:0] prev_gray;

        up_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                    4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        for (int i = 0; i < 16; i++) begin
            add(1'b1, 1'b1, W'(i + 1), up_gray[i], (i == 15), $sformatf("up%0d", i));
        end
        add(1'b1, 1'b0, 4'b1111, 4'b1000, 1'b1, "down_wrap");
        add(1'b1, 1'b0, 4'b1110, 4'b1001, 1'b0, "down_after");
        for (int i = 0; i < 5; i++) begin
            add(1'b0, 1'b0, 4'b1110, 4'b1001, 1'b0, $sformatf("hold%0d", i));
        end

        // Reset state, applied asynchronously between edges.
        #2 rst_n = 1'b0;
        #1;
        chk_main("reset", 4'b0000, 4'b0000, 1'b0);
        chk_sat("reset_sat", 4'b0000, 4'b0000, 1'b0);
        step();
        rst_n = 1'b1;

        // Table: up sequence, down wrap, hold.
        foreach (vecs[i]) begin
            prev_gray = cnt_gray;
            en = vecs[i].en;
            up = vecs[i].up;
            step();
            chk_main(vecs[i].name, vecs[i].bin, vecs[i].gray, vecs[i].tc);
            if (vecs[i].en) begin
                chk({vecs[i].name, ".onebit"}, $countones(prev_gray ^ cnt_gray), 1);
            end
        end
        en = 1'b0;

`ifdef GRAY_CNT_LOAD_EN
        // Load wins over en; the next count continues from the loaded value.
        load = 1'b1; load_gray = 4'b1110; en = 1'b1; up = 1'b0;
        step();
        chk_main("load", 4'b1011, 4'b1110, 1'b0);
        load = 1'b0; up = 1'b1;
        step();
        chk_main("load_next", 4'b1100, 4'b1010, 1'b0);
        en = 1'b0;
`endif

        // Async reset mid-count at Gray 0110.
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (4) step();
        chk_main("pre_areset", 4'b0100, 4'b0110, 1'b0);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_main("areset", 4'b0000, 4'b0000, 1'b0);
        #1 rst_n = 1'b1;
        en = 1'b1; up = 1'b1;
        step();
        chk_main("post_areset", 4'b0001, 4'b0001, 1'b0);
        en = 1'b0;

        // Saturating instance: low end, climb, then stick at the top.
        do_reset();
        en_s = 1'b1; up_s = 1'b0;
        step();
        chk_sat("sat_low", 4'b0000, 4'b0000, 1'b1);
        up_s = 1'b1;
        repeat (15) step();
        chk_sat("sat_climb", 4'b1111, 4'b1000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_sat($sformatf("sat_top%0d", i), 4'b1111, 4'b1000, 1'b1);
        end
        en_s = 1'b0;
        step();
        chk_sat("sat_idle", 4'b1111, 4'b1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised, registered Gray-code up/down counter with wrap or saturate mode, terminal-count pulse and optional parallel load of a Gray value. It generalises the team's combinational binary↔Gray converters into a clocked block. Its registered Gray output is intended as the pointer source for clock-domain-crossing FIFOs and position encoders. Both the binary and Gray views of the count come straight from flops, so the Gray bus never glitches.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2..32.
- `WRAP_MODE`, default 1: 1 means wrap at the ends; 0 means saturate at the ends.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `en`  in  1  advance the count by one step this cycle.
- `up`  in  1  direction: 1 counts up, 0 counts down; sampled only when `en`=1.
- `load`  in  1  parallel load strobe; present only with `GRAY_CNT_LOAD_EN`.
- `load_gray`  in  WIDTH  Gray-coded load value; present only with `GRAY_CNT_LOAD_EN`.
- `cnt_bin`  out  WIDTH  registered binary count.
- `cnt_gray`  out  WIDTH  registered Gray count; always equals `cnt_bin ^ (cnt_bin >> 1)`.
- `tc`  out  1  registered one-cycle terminal-count pulse.

## Operation
- State register: binary count `b`. The next-state value `b_nxt` is computed combinationally.
  - `cnt_bin` is registered from `b_nxt`.
  - `cnt_gray` is registered from `bin2gray(b_nxt)` in the same edge.
  - `cnt_gray` is never derived combinationally from `cnt_bin`.
- Priority per cycle: `load` > `en` > hold.
- `load`=1: `b_nxt = gray2bin(load_gray)` and `tc`=0. `en` and `up` are ignored that cycle.
- `en`=1, `up`=1:
  - If `b` < all-ones: `b_nxt = b+1`, `tc`=0.
  - If `b` = all-ones and `WRAP_MODE`=1: `b_nxt` = 0, `tc`=1.
  - If `b` = all-ones and `WRAP_MODE`=0: `b` holds, `tc`=1.
- `en`=1, `up`=0:
  - If `b` > 0: `b_nxt = b-1`, `tc`=0.
  - If `b` = 0 and `WRAP_MODE`=1: `b_nxt` = all-ones, `tc`=1.
  - If `b` = 0 and `WRAP_MODE`=0: `b` holds, `tc`=1.
- `en`=0 with no load: all registers hold and `tc`=0.
- Arithmetic: the add/subtract is WIDTH bits wide with no carry-out. End detection compares against the constants all-ones and zero. It does not use the carry.
- Invariant: across any non-load update, `cnt_gray` changes in exactly one bit (wrap included), or in zero bits (hold or saturate).

## Timing
- Reset (`rst_n`=0) acts asynchronously and immediately forces `cnt_bin`=0, `cnt_gray`=0 and `tc`=0, including in the middle of a count or a load.
- Release is synchronous in effect: the first `en` or `load` is honoured on the first rising edge at which `rst_n`=1.
- Latency is 1 cycle: inputs sampled at edge N appear on all outputs after edge N.
- `tc` is high for exactly the cycle that follows the edge on which the end was hit. Repeated `en` cycles while saturated give a `tc` pulse on each such edge.
- No handshake and no backpressure: every `en` cycle is honoured.

## Configuration
- Macro: `GRAY_CNT_LOAD_EN`.
- Defined: the `load` and `load_gray` ports exist, the load path uses `gray2bin`, and load takes priority over `en`.
- Undefined: both ports and the load mux are removed; the counter changes only through `en` and reset.

## Structure
- Package `gray_pkg` holds:
  - Functions `bin2gray` and `gray2bin`, width-generic through a WIDTH-sized parameterised typedef or automatic functions of up to 32 bits.
  - Local constants `CNT_ZERO` and `CNT_ONES`.
- Sub-module `gray_conv`: combinational and parametrised, with a `DIR` parameter (B2G or G2B). It is instantiated once for the next-state Gray value and once for the load path, and wraps the package functions so that they can be unit-tested standalone.
- Top: the next-state logic, a single `always` block with async reset for `b`, `cnt_gray` and `tc`, and the macro guards.

## Test plan
All scenarios use WIDTH=4.
- **Up sequence:** reset, then 16 cycles of `en`=1 and `up`=1. `cnt_gray` steps 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. `tc`=1 only with the final 0000. Every step differs in one bit.
- **Down wrap:** from 0, a single `en`=1 with `up`=0 gives `cnt_bin`=1111, `cnt_gray`=1000, `tc`=1. The next `en` gives 1110/1001 with `tc`=0.
- **Saturate:** with `WRAP_MODE`=0, hold at 1111/1000 and apply 3 cycles of `en` with `up`=1. The outputs stay 1111/1000 and `tc`=1 on each of the 3 cycles.
- **Load priority:** with `GRAY_CNT_LOAD_EN`, apply `load`=1, `load_gray`=1110 and `en`=1 in the same cycle. The result is `cnt_bin`=1011, `cnt_gray`=1110, `tc`=0. A following `en` with `up`=1 gives 1100/1010.
- **Hold:** with `en`=0 for 5 cycles, the outputs do not change and `tc`=0.
- **Async reset:** pull `rst_n` low between clock edges while the count is at 0110. The outputs read 0/0/0 before the next edge. After release, the first `en` with `up`=1 gives 0001/0001.
